// File: rtl/spike_bin_receiver.sv
// -----------------------------------------------------------------------------
// spike_bin_receiver
//
// Consumer end of the encoding-slot spike-bin stream. Bins arrive one per
// valid_bin in channel order 0..CHANNELS-1 and are captured into the write half
// of a ping-pong frame buffer (2 x CHANNELS x 4 bits). A completed frame is
// swapped into the read half and presented to the SNN core through a
// synchronous read port until inference_done releases it.
//
// Optional feature macro: RX_ACTIVE_COUNT_EN
//   defined   - per-frame count of active channels is accumulated and reported
//               on active_count.
//   undefined - accumulator removed, active_count tied to 0.
//
// Ports
//   clk                  in   single clock
//   rst                  in   synchronous, active-high reset
//   valid_bin            in   one bin present this cycle
//   spike_bin[3:0]       in   spike bin for the current channel
//   active_group_out_bin in   current channel active flag
//   inference_done       in   1-cycle pulse releasing the presented frame
//   overrun_clr          in   clears overrun (a same-cycle set wins)
//   rd_en                in   read strobe
//   rd_adr[AW-1:0]       in   channel to read
//   rd_dat[3:0]          out  read data, one cycle after rd_en
//   rd_valid             out  1-cycle pulse marking rd_dat
//   frame_ready          out  a complete frame is presented in the read bank
//   active_count[CW-1:0] out  active channels in the presented frame
//   overrun              out  sticky: at least one frame was dropped
//
// FSM states
//   state  | meaning
//   S_FILL | bins written into the write bank; swap on last channel if possible
//   S_PEND | full frame parked in write bank; incoming bins dropped (overrun)
//   S_SKIP | realigning to frame start; bins dropped silently until channel end
// -----------------------------------------------------------------------------
module spike_bin_receiver #(
   parameter int CHANNELS = 128,
   parameter int AW       = $clog2(CHANNELS),
   parameter int CW       = $clog2(CHANNELS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_bin,
   input  logic [3:0]    spike_bin,
   input  logic          active_group_out_bin,
   input  logic          inference_done,
   input  logic          overrun_clr,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_adr,
   output logic [3:0]    rd_dat,
   output logic          rd_valid,
   output logic          frame_ready,
   output logic [CW-1:0] active_count,
   output logic          overrun
);

   localparam logic [AW-1:0] LAST_CH = AW'(CHANNELS - 1);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_PEND = 2'd1,
      S_SKIP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] ch_idx_q, ch_idx_d;
   logic          wr_sel_q, wr_sel_d;
   logic          frame_ready_q, frame_ready_d;
   logic          overrun_q, overrun_d;
   logic          wr_en;
   logic          swap_fill;
   logic          swap_pend;
   logic          last_ch;

   logic [3:0]    bank0_q [CHANNELS];
   logic [3:0]    bank1_q [CHANNELS];
   logic [3:0]    rd_dat_q;
   logic          rd_valid_q;
   logic [3:0]    rd_word;

   assign last_ch = (ch_idx_q == LAST_CH);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d       = state_q;
      ch_idx_d      = ch_idx_q;
      wr_sel_d      = wr_sel_q;
      frame_ready_d = frame_ready_q;
      overrun_d     = overrun_q;
      wr_en         = 1'b0;
      swap_fill     = 1'b0;
      swap_pend     = 1'b0;

      // Channel position tracks the stream regardless of what we do with it.
      if (valid_bin) begin
         ch_idx_d = last_ch ? '0 : ch_idx_q + AW'(1);
      end

      if (overrun_clr) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         S_FILL: begin
            if (inference_done) begin
               frame_ready_d = 1'b0;
            end
            if (valid_bin) begin
               wr_en = 1'b1;
               if (last_ch) begin
                  // Read bank is free if idle or being released this cycle.
                  if (!frame_ready_q || inference_done) begin
                     swap_fill     = 1'b1;
                     wr_sel_d      = ~wr_sel_q;
                     frame_ready_d = 1'b1;
                  end else begin
                     state_d = S_PEND;
                  end
               end
            end
         end

         S_PEND: begin
            if (valid_bin) begin
               overrun_d = 1'b1;
            end
            if (inference_done) begin
               swap_pend     = 1'b1;
               wr_sel_d      = ~wr_sel_q;
               frame_ready_d = 1'b1;
               // Only resume filling on a frame boundary.
               state_d       = (ch_idx_d == '0) ? S_FILL : S_SKIP;
            end
         end

         S_SKIP: begin
            if (inference_done) begin
               frame_ready_d = 1'b0;
            end
            if (valid_bin && last_ch) begin
               state_d = S_FILL;
            end
         end

         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_FILL;
         ch_idx_q      <= '0;
         wr_sel_q      <= 1'b0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ch_idx_q      <= ch_idx_d;
         wr_sel_q      <= wr_sel_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
      end
   end

   // ------------------------------------------------------- active count
`ifdef RX_ACTIVE_COUNT_EN
   logic [CW-1:0] act_acc_q, act_acc_d;
   logic [CW-1:0] active_count_q, active_count_d;
   logic [CW-1:0] act_sum;

   // Channel 0 starts a fresh frame, so the old total is dropped there.
   // The accumulator only moves in FILL, so in PEND it still holds the
   // parked frame's total for the later swap.
   assign act_sum = ((ch_idx_q == '0) ? '0 : act_acc_q) + CW'(active_group_out_bin);

   always_comb begin
      act_acc_d      = act_acc_q;
      active_count_d = active_count_q;
      if (state_q == S_FILL && valid_bin) begin
         act_acc_d = act_sum;
      end
      if (swap_fill) begin
         active_count_d = act_sum;
      end else if (swap_pend) begin
         active_count_d = act_acc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         act_acc_q      <= '0;
         active_count_q <= '0;
      end else begin
         act_acc_q      <= act_acc_d;
         active_count_q <= active_count_d;
      end
   end

   assign active_count = active_count_q;
`else
   logic unused_act;
   assign unused_act   = active_group_out_bin ^ swap_fill ^ swap_pend;
   assign active_count = '0;
`endif

   // ------------------------------------------------------- frame banks
   // No reset: contents are only meaningful once a frame is presented.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         if (wr_sel_q) begin
            bank1_q[ch_idx_q] <= spike_bin;
         end else begin
            bank0_q[ch_idx_q] <= spike_bin;
         end
      end
   end

   // Uses the registered wr_sel, so a read in a swap cycle sees the old bank.
   always_comb begin
      rd_word = '0;
      if (int'(rd_adr) < CHANNELS) begin
         rd_word = wr_sel_q ? bank0_q[rd_adr] : bank1_q[rd_adr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_dat_q   <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) begin
            rd_dat_q <= rd_word;
         end
      end
   end

   assign rd_dat      = rd_dat_q;
   assign rd_valid    = rd_valid_q;
   assign frame_ready = frame_ready_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_spike_bin_receiver.sv
// -----------------------------------------------------------------------------
// Bench for spike_bin_receiver with CHANNELS=4. Read data goes through a
// scoreboard queue popped by a monitor on rd_valid; status outputs are
// compared directly after each stimulus cycle.
// -----------------------------------------------------------------------------
module tb_spike_bin_receiver;

   localparam int CH = 4;
   localparam int AW = 2;
   localparam int CW = 3;
`ifdef RX_ACTIVE_COUNT_EN
   localparam bit AC_EN = 1'b1;
`else
   localparam bit AC_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid_bin = 1'b0;
   logic [3:0]    spike_bin = '0;
   logic          active_group_out_bin = 1'b0;
   logic          inference_done = 1'b0;
   logic          overrun_clr = 1'b0;
   logic          rd_en = 1'b0;
   logic [AW-1:0] rd_adr = '0;
   logic [3:0]    rd_dat;
   logic          rd_valid;
   logic          frame_ready;
   logic [CW-1:0] active_count;
   logic          overrun;

   int checks = 0;
   int errors = 0;
   logic [3:0] exp_q [$];

   spike_bin_receiver #(.CHANNELS(CH)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .valid_bin            (valid_bin),
      .spike_bin            (spike_bin),
      .active_group_out_bin (active_group_out_bin),
      .inference_done       (inference_done),
      .overrun_clr          (overrun_clr),
      .rd_en                (rd_en),
      .rd_adr               (rd_adr),
      .rd_dat               (rd_dat),
      .rd_valid             (rd_valid),
      .frame_ready          (frame_ready),
      .active_count         (active_count),
      .overrun              (overrun)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] eac(input int n);
      return AC_EN ? 32'(n) : 32'd0;
   endfunction

   // One stimulus cycle; everything driven here is dropped afterwards.
   task automatic drive(input logic vb, input logic [3:0] v, input logic a,
                        input logic done, input logic clr);
      valid_bin            = vb;
      spike_bin            = v;
      active_group_out_bin = a;
      inference_done       = done;
      overrun_clr          = clr;
      cyc();
      valid_bin            = 1'b0;
      inference_done       = 1'b0;
      overrun_clr          = 1'b0;
   endtask

   task automatic bin(input logic [3:0] v, input logic a);
      drive(1'b1, v, a, 1'b0, 1'b0);
   endtask

   task automatic release_frame();
      drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic rd(input int adr, input logic [3:0] exp);
      rd_en  = 1'b1;
      rd_adr = AW'(adr);
      exp_q.push_back(exp);
      cyc();
      rd_en  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   // Monitor: every rd_valid must match the oldest outstanding read.
   always @(negedge clk) begin
      if (rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_valid unexpected: got data %0h expected no read", rd_dat);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (rd_dat !== e) begin
               errors++;
               $display("FAIL rd_dat: got %0h expected %0h", rd_dat, e);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ---------------- reset
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst rd_dat", rd_dat, 0);
      chk("rst rd_valid", rd_valid, 0);
      chk("rst frame_ready", frame_ready, 0);
      chk("rst active_count", active_count, 0);
      chk("rst overrun", overrun, 0);

      // ---------------- single frame
      bin(4'h1, 1'b1);
      bin(4'h0, 1'b0);
      bin(4'hF, 1'b1);
      chk("f1 frame_ready before last", frame_ready, 0);
      bin(4'h3, 1'b1);
      chk("f1 frame_ready", frame_ready, 1);
      chk("f1 active_count", active_count, eac(3));
      rd(0, 4'h1);
      rd(1, 4'h0);
      rd(2, 4'hF);
      rd(3, 4'h3);

      // ---------------- release and next frame
      release_frame();
      chk("f2 frame_ready released", frame_ready, 0);
      bin(4'h2, 1'b1);
      bin(4'h2, 1'b1);
      bin(4'h2, 1'b0);
      chk("f2 frame_ready during fill", frame_ready, 0);
      bin(4'h2, 1'b0);
      chk("f2 frame_ready", frame_ready, 1);
      chk("f2 active_count", active_count, eac(2));
      chk("f2 overrun", overrun, 0);
      for (int i = 0; i < CH; i++) rd(i, 4'h2);

      // ---------------- overrun, PEND, SKIP
      release_frame();
      for (int i = 0; i < CH; i++) bin(4'h4, 1'b1);
      chk("fa frame_ready", frame_ready, 1);
      chk("fa active_count", active_count, eac(4));
      rd(0, 4'h4);
      rd(3, 4'h4);
      bin(4'h9, 1'b0);
      bin(4'h8, 1'b1);
      bin(4'h7, 1'b0);
      bin(4'h6, 1'b1);
      chk("fb parked frame_ready", frame_ready, 1);
      chk("fb parked active_count", active_count, eac(4));
      chk("fb parked overrun", overrun, 0);
      rd(1, 4'h4);
      bin(4'hA, 1'b1);
      chk("overrun after first drop", overrun, 1);
      bin(4'hA, 1'b1);
      release_frame();
      chk("fb presented frame_ready", frame_ready, 1);
      chk("fb presented active_count", active_count, eac(2));
      rd(0, 4'h9);
      rd(1, 4'h8);
      rd(2, 4'h7);
      rd(3, 4'h6);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("overrun cleared", overrun, 0);
      bin(4'hB, 1'b1);
      bin(4'hB, 1'b1);
      chk("skip keeps overrun clear", overrun, 0);
      bin(4'hC, 1'b1);
      bin(4'hC, 1'b0);
      bin(4'hC, 1'b0);
      bin(4'hC, 1'b0);
      chk("fc parked active_count", active_count, eac(2));
      chk("fc parked overrun", overrun, 0);
      rd(0, 4'h9);
      release_frame();
      chk("fc frame_ready", frame_ready, 1);
      chk("fc active_count", active_count, eac(1));
      for (int i = 0; i < CH; i++) rd(i, 4'hC);

      // ---------------- done coincident with last bin
      bin(4'hD, 1'b1);
      chk("fd frame_ready ch0", frame_ready, 1);
      bin(4'hE, 1'b1);
      chk("fd frame_ready ch1", frame_ready, 1);
      bin(4'h1, 1'b1);
      chk("fd frame_ready ch2", frame_ready, 1);
      rd_en  = 1'b1;
      rd_adr = '0;
      exp_q.push_back(4'hC);
      drive(1'b1, 4'h2, 1'b0, 1'b1, 1'b0);
      rd_en  = 1'b0;
      chk("fd frame_ready swap", frame_ready, 1);
      chk("fd active_count", active_count, eac(3));
      rd(0, 4'hD);
      rd(1, 4'hE);
      rd(2, 4'h1);
      rd(3, 4'h2);

      // ---------------- overrun set beats clear
      for (int i = 0; i < CH; i++) bin(4'h3, 1'b0);
      drive(1'b1, 4'h3, 1'b0, 1'b0, 1'b1);
      chk("overrun set wins over clear", overrun, 1);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      chk("overrun clr alone", overrun, 0);

      // ---------------- reset mid-frame
      do_reset();
      bin(4'h6, 1'b1);
      bin(4'h6, 1'b1);
      do_reset();
      chk("rst2 rd_dat", rd_dat, 0);
      chk("rst2 frame_ready", frame_ready, 0);
      chk("rst2 active_count", active_count, 0);
      chk("rst2 overrun", overrun, 0);
      bin(4'h5, 1'b0);
      bin(4'h5, 1'b1);
      bin(4'h5, 1'b1);
      bin(4'h5, 1'b0);
      chk("f5 frame_ready", frame_ready, 1);
      chk("f5 active_count", active_count, eac(2));
      for (int i = 0; i < CH; i++) rd(i, 4'h5);

      cyc();
      cyc();
      chk("reads outstanding", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
